// File: rtl/cam_init_seq.sv
// Camera sensor bring-up sequencer: sequences power/reset pins, then walks a ROM
// table of SCCB writes, read-back verified writes and delays until END or the last entry.
module cam_init_seq #(
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 256,
    parameter int T_PWR      = 50000,
    parameter int T_RST      = 50000,
    parameter int T_BOOT     = 150000,
    parameter int DLY_UNIT   = 50000,
    parameter int MAX_RETRY  = 3,
    parameter bit AUTO_START = 1'b1,
    localparam int IW        = $clog2(DEPTH),
    localparam int EW        = 2 + ADDR_W + 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [IW-1:0]     tbl_idx,
    input  logic [EW-1:0]     tbl_entry,
    output logic              bus_start,
    output logic              bus_rd,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    input  logic              bus_busy,
    input  logic              bus_done,
    input  logic [7:0]        bus_rdata,
    output logic              cam_pwdn,
    output logic              cam_resetb,
    output logic              init_done,
    output logic              init_err,
    output logic [IW-1:0]     err_idx,
    output logic              busy
);

    localparam int            RW        = $clog2(MAX_RETRY + 2);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);
    localparam logic [31:0]   PWR_LAST  = 32'(T_PWR - 1);
    localparam logic [31:0]   RST_LAST  = 32'(T_RST - 1);
    localparam logic [31:0]   BOOT_LAST = 32'(T_BOOT - 1);
    localparam logic [31:0]   DLY_LEN   = 32'(DLY_UNIT);

    localparam logic [1:0] OP_WRITE   = 2'b00;
    localparam logic [1:0] OP_DELAY   = 2'b01;
    localparam logic [1:0] OP_END     = 2'b10;
    localparam logic [1:0] OP_WVERIFY = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE, ST_PWR, ST_RST, ST_BOOT, ST_FETCH, ST_DECODE, ST_ISSUE,
        ST_WAIT_BUS, ST_RD_ISSUE, ST_RD_WAIT, ST_DELAY, ST_DONE, ST_ERROR
    } state_e;

    state_e              state_r, state_n;
    logic [31:0]         cnt_r, cnt_n;
    logic [IW-1:0]       tbl_idx_r, tbl_idx_n;
    logic [RW-1:0]       retry_r, retry_n;
    logic [1:0]          op_r, op_n;
    logic [7:0]          data_r, data_n;
    logic                armed_r;
    logic                start_meta_r, start_sync_r, start_prev_r;
    logic                bus_start_r, bus_start_n;
    logic                bus_rd_r, bus_rd_n;
    logic [ADDR_W-1:0]   bus_addr_r, bus_addr_n;
    logic [7:0]          bus_wdata_r, bus_wdata_n;
    logic                cam_pwdn_r, cam_pwdn_n;
    logic                cam_resetb_r, cam_resetb_n;
    logic                init_done_r, init_done_n;
    logic                init_err_r, init_err_n;
    logic [IW-1:0]       err_idx_r, err_idx_n;
    logic                busy_r, busy_n;
    logic                trig_s;
    logic                step_s;
    logic [31:0]         dly_len_s;

    assign trig_s    = start_sync_r ^ start_prev_r;
    assign dly_len_s = {24'd0, data_r} * DLY_LEN;

    // Next-state, counters and registered-output next values
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        tbl_idx_n   = tbl_idx_r;
        retry_n     = retry_r;
        op_n        = op_r;
        data_n      = data_r;
        bus_start_n = 1'b0;
        bus_rd_n    = bus_rd_r;
        bus_addr_n  = bus_addr_r;
        bus_wdata_n = bus_wdata_r;
        init_done_n = init_done_r;
        init_err_n  = init_err_r;
        err_idx_n   = err_idx_r;
        step_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (armed_r) begin
                    state_n = ST_PWR;
                    cnt_n   = 32'd0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_PWR: begin
                if (cnt_r == PWR_LAST) begin
                    state_n = ST_RST;
                    cnt_n   = 32'd0;
                end else begin
                    cnt_n = cnt_r + 32'd1;
                end
            end
            ST_RST: begin
                if (cnt_r == RST_LAST) begin
                    state_n = ST_BOOT;
                    cnt_n   = 32'd0;
                end else begin
                    cnt_n = cnt_r + 32'd1;
                end
            end
            ST_BOOT: begin
                if (cnt_r == BOOT_LAST) begin
                    state_n = ST_FETCH;
                    cnt_n   = 32'd0;
                end else begin
                    cnt_n = cnt_r + 32'd1;
                end
            end
            ST_FETCH: begin
                state_n = ST_DECODE;
            end
            ST_DECODE: begin
                op_n   = tbl_entry[EW-1 -: 2];
                data_n = tbl_entry[7:0];
                case (tbl_entry[EW-1 -: 2])
                    OP_WRITE, OP_WVERIFY: begin
                        bus_addr_n  = tbl_entry[ADDR_W+7:8];
                        bus_wdata_n = tbl_entry[7:0];
                        state_n     = ST_ISSUE;
                    end
                    OP_DELAY: begin
                        cnt_n   = 32'd0;
                        state_n = ST_DELAY;
                    end
                    OP_END: begin
                        init_done_n = 1'b1;
                        state_n     = ST_DONE;
                    end
                    default: begin
                        state_n = ST_ERROR;
                    end
                endcase
            end
            ST_ISSUE: begin
                if (!bus_busy) begin
                    bus_start_n = 1'b1;
                    bus_rd_n    = 1'b0;
                    state_n     = ST_WAIT_BUS;
                end else begin
                    state_n = ST_ISSUE;
                end
            end
            ST_WAIT_BUS: begin
                if (bus_done && op_r == OP_WVERIFY) begin
                    state_n = ST_RD_ISSUE;
                end else if (bus_done) begin
                    step_s = 1'b1;
                end else begin
                    state_n = ST_WAIT_BUS;
                end
            end
            ST_RD_ISSUE: begin
                if (!bus_busy) begin
                    bus_start_n = 1'b1;
                    bus_rd_n    = 1'b1;
                    state_n     = ST_RD_WAIT;
                end else begin
                    state_n = ST_RD_ISSUE;
                end
            end
            ST_RD_WAIT: begin
                if (!bus_done) begin
                    state_n = ST_RD_WAIT;
                end else if (bus_rdata == data_r) begin
                    retry_n = '0;
                    step_s  = 1'b1;
                end else if (retry_r < RETRY_MAX) begin
                    retry_n = retry_r + 1'b1;
                    state_n = ST_ISSUE;
                end else begin
                    init_err_n = 1'b1;
                    err_idx_n  = tbl_idx_r;
                    state_n    = ST_ERROR;
                end
            end
            ST_DELAY: begin
                if (cnt_r == dly_len_s) begin
                    step_s = 1'b1;
                end else begin
                    cnt_n = cnt_r + 32'd1;
                end
            end
            ST_DONE, ST_ERROR: begin
                state_n = state_r;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // A completed entry either ends the table at the last index or moves to the next one
        if (step_s && tbl_idx_r == LAST_IDX) begin
            init_done_n = 1'b1;
            state_n     = ST_DONE;
        end else if (step_s) begin
            tbl_idx_n = tbl_idx_r + 1'b1;
            state_n   = ST_FETCH;
        end else begin
            tbl_idx_n = tbl_idx_n;
        end

        // Restart overrides everything; an in-flight bus transfer is left to finish on its own
        if (trig_s) begin
            state_n     = ST_PWR;
            cnt_n       = 32'd0;
            tbl_idx_n   = '0;
            retry_n     = '0;
            init_done_n = 1'b0;
            init_err_n  = 1'b0;
            bus_start_n = 1'b0;
        end else begin
            state_n = state_n;
        end

        cam_pwdn_n   = (state_n == ST_PWR);
        cam_resetb_n = !((state_n == ST_PWR) || (state_n == ST_RST));
        busy_n       = !((state_n == ST_IDLE) || (state_n == ST_DONE) || (state_n == ST_ERROR));
    end

    // State, counters, start synchroniser and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 32'd0;
            tbl_idx_r    <= '0;
            retry_r      <= '0;
            op_r         <= 2'b00;
            data_r       <= 8'h00;
            armed_r      <= AUTO_START;
            start_meta_r <= 1'b0;
            start_sync_r <= 1'b0;
            start_prev_r <= 1'b0;
            bus_start_r  <= 1'b0;
            bus_rd_r     <= 1'b0;
            bus_addr_r   <= '0;
            bus_wdata_r  <= 8'h00;
            cam_pwdn_r   <= 1'b0;
            cam_resetb_r <= 1'b1;
            init_done_r  <= 1'b0;
            init_err_r   <= 1'b0;
            err_idx_r    <= '0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_n;
            cnt_r        <= cnt_n;
            tbl_idx_r    <= tbl_idx_n;
            retry_r      <= retry_n;
            op_r         <= op_n;
            data_r       <= data_n;
            armed_r      <= 1'b0;
            start_meta_r <= start;
            start_sync_r <= start_meta_r;
            start_prev_r <= start_sync_r;
            bus_start_r  <= bus_start_n;
            bus_rd_r     <= bus_rd_n;
            bus_addr_r   <= bus_addr_n;
            bus_wdata_r  <= bus_wdata_n;
            cam_pwdn_r   <= cam_pwdn_n;
            cam_resetb_r <= cam_resetb_n;
            init_done_r  <= init_done_n;
            init_err_r   <= init_err_n;
            err_idx_r    <= err_idx_n;
            busy_r       <= busy_n;
        end
    end

    assign tbl_idx    = tbl_idx_r;
    assign bus_start  = bus_start_r;
    assign bus_rd     = bus_rd_r;
    assign bus_addr   = bus_addr_r;
    assign bus_wdata  = bus_wdata_r;
    assign cam_pwdn   = cam_pwdn_r;
    assign cam_resetb = cam_resetb_r;
    assign init_done  = init_done_r;
    assign init_err   = init_err_r;
    assign err_idx    = err_idx_r;
    assign busy       = busy_r;

endmodule
